// File: rtl/pulpemu_uart_pkg.sv
// Shared constants for the emulation UART: register offsets, CONFIG field positions,
// serializer states and the data parity helper.
package pulpemu_uart_pkg;

    localparam logic [4:0] REG_TXDATA = 5'h00;
    localparam logic [4:0] REG_CONFIG = 5'h04;
    localparam logic [4:0] REG_STATUS = 5'h08;
    localparam logic [4:0] REG_LEVEL  = 5'h0C;
    localparam logic [4:0] REG_IRQ_EN = 5'h10;

    localparam int CFG_DIV_MSB    = 31;
    localparam int CFG_DIV_LSB    = 16;
    localparam int CFG_EN_BIT     = 15;
    localparam int CFG_PAR_BIT    = 14;
    localparam int CFG_BITS_MSB   = 13;
    localparam int CFG_BITS_LSB   = 12;
    localparam int CFG_STOP_BIT   = 11;
    localparam int STATUS_IRQ_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Even parity over the 5..8 data bits that actually go on the line.
    function automatic logic data_parity(input logic [7:0] data, input logic [1:0] bits);
        logic p;
        case (bits)
            2'b00:   p = ^data[4:0];
            2'b01:   p = ^data[5:0];
            2'b10:   p = ^data[6:0];
            default: p = ^data[7:0];
        endcase
        return p;
    endfunction

endpackage

// File: rtl/pulpemu_uart_tx_fifo.sv
// Synchronous byte FIFO with occupancy output; pushes while full are dropped,
// a simultaneous pop is still honoured.
module pulpemu_uart_tx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (level_r == LW'(DEPTH));
    assign empty     = (level_r == {LW{1'b0}});
    assign level     = level_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage array; no reset, reset only discards entries via the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LW'(1'b1);
                2'b01:   level_r <= level_r - LW'(1'b1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/pulpemu_uart_tx.sv
// APB-programmable UART transmitter: TX FIFO plus serializer FSM.
// Optional TX-empty interrupt and IRQ_EN register enabled by PULPEMU_UART_TX_IRQ_EN.
module pulpemu_uart_tx
    import pulpemu_uart_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int APB_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [APB_ADDR_WIDTH-1:0] apb_paddr,
    input  logic                      apb_psel,
    input  logic                      apb_penable,
    input  logic                      apb_pwrite,
    input  logic [31:0]               apb_pwdata,
    output logic [31:0]               apb_prdata,
    output logic                      apb_pready,
    output logic                      apb_pslverr,
    output logic                      uart_tx_o,
    output logic                      uart_irq_o,
    output logic                      busy_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic             access_s;
    logic             wr_s;
    logic             rd_s;
    logic [4:0]       addr_s;
    logic             push_req_s;
    logic [31:0]      prdata_s;
    logic             irq_pend_s;
    logic             unused_s;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [7:0]       fifo_rdata_s;
    logic [LVL_W-1:0] fifo_level_s;

    logic [15:0]      cfg_div_r;
    logic             cfg_en_r;
    logic             cfg_par_r;
    logic [1:0]       cfg_bits_r;
    logic             cfg_stop_r;

    logic [15:0]      sh_div_r;
    logic             sh_par_r;
    logic [1:0]       sh_bits_r;
    logic             sh_stop_r;
    logic             sh_pbit_r;

    tx_state_e        state_r;
    tx_state_e        state_n;
    logic [15:0]      cnt_r;
    logic [15:0]      cnt_n;
    logic [2:0]       idx_r;
    logic [2:0]       idx_n;
    logic [7:0]       shift_r;
    logic [7:0]       shift_n;
    logic             tx_r;
    logic             tx_n;
    logic             busy_r;
    logic             pop_s;
    logic             load_s;
    logic             bit_done_s;
    logic             start_ok_s;
    logic [2:0]       last_idx_s;

    assign access_s    = apb_psel & apb_penable;
    assign wr_s        = access_s & apb_pwrite;
    assign rd_s        = access_s & ~apb_pwrite;
    assign addr_s      = apb_paddr[4:0];
    assign push_req_s  = wr_s & (addr_s == REG_TXDATA);
    assign apb_pready  = 1'b1;
    assign apb_pslverr = push_req_s & fifo_full_s;
    assign apb_prdata  = prdata_s;
    assign uart_tx_o   = tx_r;
    assign busy_o      = busy_r;
    assign unused_s    = ^{apb_paddr[APB_ADDR_WIDTH-1:5], apb_pwdata[10:8]};

    pulpemu_uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req_s),
        .wdata (apb_pwdata[7:0]),
        .pop   (pop_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

    // Live CONFIG register; the serializer only sees it through the shadow copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_div_r  <= 16'h0000;
            cfg_en_r   <= 1'b0;
            cfg_par_r  <= 1'b0;
            cfg_bits_r <= 2'b00;
            cfg_stop_r <= 1'b0;
        end else if (wr_s && (addr_s == REG_CONFIG)) begin
            cfg_div_r  <= apb_pwdata[CFG_DIV_MSB:CFG_DIV_LSB];
            cfg_en_r   <= apb_pwdata[CFG_EN_BIT];
            cfg_par_r  <= apb_pwdata[CFG_PAR_BIT];
            cfg_bits_r <= apb_pwdata[CFG_BITS_MSB:CFG_BITS_LSB];
            cfg_stop_r <= apb_pwdata[CFG_STOP_BIT];
        end
    end

`ifdef PULPEMU_UART_TX_IRQ_EN
    logic irq_en_r;
    logic irq_pend_r;
    logic irq_r;
    logic irq_set_s;
    logic irq_clr_s;

    // Pending is raised when the last queued frame finishes and the FSM falls back to idle.
    assign irq_set_s  = (state_r == ST_STOP) && (state_n == ST_IDLE) && fifo_empty_s;
    assign irq_clr_s  = push_req_s |
                        (wr_s && (addr_s == REG_STATUS) && apb_pwdata[STATUS_IRQ_BIT]);
    assign irq_pend_s = irq_pend_r;
    assign uart_irq_o = irq_r;

    // Interrupt enable, pending flag (clear wins over set) and registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_r   <= 1'b0;
            irq_pend_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (irq_clr_s) begin
                irq_pend_r <= 1'b0;
            end else if (irq_set_s) begin
                irq_pend_r <= 1'b1;
            end
            if (wr_s && (addr_s == REG_IRQ_EN)) begin
                irq_en_r <= apb_pwdata[0];
            end
            irq_r <= irq_pend_r & irq_en_r;
        end
    end
`else
    assign irq_pend_s = 1'b0;
    assign uart_irq_o = 1'b0;
`endif

    // Read mux, only driven during the access phase.
    always_comb begin
        prdata_s = 32'h0000_0000;
        if (rd_s) begin
            case (addr_s)
                REG_CONFIG: prdata_s = {cfg_div_r, cfg_en_r, cfg_par_r, cfg_bits_r,
                                        cfg_stop_r, 11'h000};
                REG_STATUS: prdata_s = {28'h000_0000, irq_pend_s, fifo_full_s,
                                        fifo_empty_s, busy_r};
                REG_LEVEL:  prdata_s = 32'(fifo_level_s);
`ifdef PULPEMU_UART_TX_IRQ_EN
                REG_IRQ_EN: prdata_s = {31'h0000_0000, irq_en_r};
`endif
                default:    prdata_s = 32'h0000_0000;
            endcase
        end else begin
            prdata_s = 32'h0000_0000;
        end
    end

    assign start_ok_s = cfg_en_r & ~fifo_empty_s;
    assign bit_done_s = (cnt_r == sh_div_r);
    assign last_idx_s = {1'b1, sh_bits_r};

    // Serializer next state; tx_n is the line value for the state being entered.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        idx_n   = idx_r;
        shift_n = shift_r;
        tx_n    = 1'b1;
        pop_s   = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    pop_s   = 1'b1;
                    load_s  = 1'b1;
                    shift_n = fifo_rdata_s;
                    cnt_n   = 16'h0000;
                    state_n = ST_START;
                    tx_n    = 1'b0;
                end else begin
                    tx_n    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    cnt_n   = 16'h0000;
                    idx_n   = 3'h0;
                    state_n = ST_DATA;
                    tx_n    = shift_r[0];
                end else begin
                    cnt_n   = cnt_r + 16'h0001;
                    tx_n    = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    cnt_n = 16'h0000;
                    if (idx_r == last_idx_s) begin
                        if (sh_par_r) begin
                            state_n = ST_PARITY;
                            tx_n    = sh_pbit_r;
                        end else begin
                            state_n = ST_STOP;
                            idx_n   = 3'h0;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n   = idx_r + 3'h1;
                        shift_n = {1'b0, shift_r[7:1]};
                        tx_n    = shift_r[1];
                    end
                end else begin
                    cnt_n = cnt_r + 16'h0001;
                    tx_n  = shift_r[0];
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    cnt_n   = 16'h0000;
                    idx_n   = 3'h0;
                    state_n = ST_STOP;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n   = cnt_r + 16'h0001;
                    tx_n    = sh_pbit_r;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    cnt_n = 16'h0000;
                    if (idx_r[0] == sh_stop_r) begin
                        // Back-to-back frames: next start bit follows the stop bit directly.
                        if (start_ok_s) begin
                            pop_s   = 1'b1;
                            load_s  = 1'b1;
                            shift_n = fifo_rdata_s;
                            state_n = ST_START;
                            tx_n    = 1'b0;
                        end else begin
                            state_n = ST_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        idx_n = idx_r + 3'h1;
                        tx_n  = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r + 16'h0001;
                    tx_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = 16'h0000;
                idx_n   = 3'h0;
                tx_n    = 1'b1;
            end
        endcase
    end

    // Serializer state, line and busy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'h0000;
            idx_r   <= 3'h0;
            shift_r <= 8'h00;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            idx_r   <= idx_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
            busy_r  <= (state_n != ST_IDLE);
        end
    end

    // Per-frame shadow of the frame format, captured when a byte is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_div_r  <= 16'h0000;
            sh_par_r  <= 1'b0;
            sh_bits_r <= 2'b00;
            sh_stop_r <= 1'b0;
            sh_pbit_r <= 1'b0;
        end else if (load_s) begin
            sh_div_r  <= cfg_div_r;
            sh_par_r  <= cfg_par_r;
            sh_bits_r <= cfg_bits_r;
            sh_stop_r <= cfg_stop_r;
            sh_pbit_r <= data_parity(fifo_rdata_s, cfg_bits_r);
        end
    end

endmodule

// File: tb/tb_pulpemu_uart_tx.sv
// Directed bench for pulpemu_uart_tx: expected frames are queued at push time and
// compared cycle by cycle against captured line samples.
module tb_pulpemu_uart_tx;

`ifdef PULPEMU_UART_TX_IRQ_EN
    localparam logic IRQ_FEAT = 1'b1;
`else
    localparam logic IRQ_FEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] apb_paddr = 32'h0;
    logic        apb_psel = 1'b0;
    logic        apb_penable = 1'b0;
    logic        apb_pwrite = 1'b0;
    logic [31:0] apb_pwdata = 32'h0;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;
    logic        uart_tx_o;
    logic        uart_irq_o;
    logic        busy_o;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         par_en;
        int         nstop;
        int         div;
        bit         b2b;
    } frame_t;

    frame_t     exp_q[$];
    logic [1:0] smp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;

    pulpemu_uart_tx dut (
        .clk         (clk),
        .rst         (rst),
        .apb_paddr   (apb_paddr),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr),
        .uart_tx_o   (uart_tx_o),
        .uart_irq_o  (uart_irq_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Line capture: one {busy, tx} sample per cycle, just after the rising edge.
    always @(posedge clk) begin
        #1;
        smp_q.push_back({busy_o, uart_tx_o});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output logic err);
        apb_paddr   = addr;
        apb_pwdata  = data;
        apb_pwrite  = 1'b1;
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        tick();
        apb_penable = 1'b1;
        #1;
        err = apb_pslverr;
        @(posedge clk);
        #1;
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
        apb_pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        apb_paddr   = addr;
        apb_pwrite  = 1'b0;
        apb_psel    = 1'b1;
        apb_penable = 1'b0;
        tick();
        apb_penable = 1'b1;
        #1;
        data = apb_prdata;
        @(posedge clk);
        #1;
        apb_psel    = 1'b0;
        apb_penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic err;
        apb_write(addr, data, err);
        check($sformatf("wr_err_%02h", addr[7:0]), 32'(err), 32'h0);
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, d);
        check(tag, d, exp);
    endtask

    task automatic push_byte(input logic [7:0] data, input int nbits, input bit par_en,
                             input int nstop, input int div, input bit b2b);
        frame_t f;
        wr(32'h00, {24'h0, data});
        f.data = data; f.nbits = nbits; f.par_en = par_en;
        f.nstop = nstop; f.div = div; f.b2b = b2b;
        exp_q.push_back(f);
    endtask

    task automatic get_sample(output logic [1:0] s);
        int t = 0;
        while (smp_q.size() == 0 && t < 1000) begin
            @(posedge clk);
            #2;
            t++;
        end
        n_cmp++;
        assert (smp_q.size() != 0) else begin
            n_err++;
            $error("FAIL sample_timeout: observed no line sample after %0d cycles expected one", t);
        end
        if (smp_q.size() != 0) s = smp_q.pop_front();
        else s = 2'b01;
    endtask

    task automatic check_frames();
        frame_t     f;
        logic [1:0] s;
        bit         seq[$];
        bit         p;
        while (exp_q.size() > 0) begin
            f = exp_q.pop_front();
            seq.delete();
            seq.push_back(1'b0);
            p = 1'b0;
            for (int i = 0; i < f.nbits; i++) begin
                seq.push_back(f.data[i]);
                p ^= f.data[i];
            end
            if (f.par_en) seq.push_back(p);
            for (int i = 0; i < f.nstop; i++) seq.push_back(1'b1);
            get_sample(s);
            if (!f.b2b) begin
                for (int w = 0; w < 300 && s[0] === 1'b1; w++) get_sample(s);
            end
            check($sformatf("frame_%02h_start", f.data), 32'(s[0]), 32'h0);
            for (int b = 0; b < seq.size(); b++) begin
                int good = 0;
                for (int c = 0; c <= f.div; c++) begin
                    if (b != 0 || c != 0) get_sample(s);
                    if (s[0] === seq[b] && s[1] === 1'b1) good++;
                end
                check($sformatf("frame_%02h_bit%0d_cycles", f.data, b), 32'(good), 32'(f.div + 1));
            end
        end
    endtask

    task automatic check_idle(input string tag);
        logic [1:0] s;
        get_sample(s);
        check(tag, {30'h0, s}, 32'h1);
    endtask

    initial begin
        logic        err;
        logic [31:0] status_done;
        status_done = {28'h0, IRQ_FEAT, 1'b0, 1'b1, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_tx", 32'(uart_tx_o), 32'h1);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_irq", 32'(uart_irq_o), 32'h0);
        check("rst_prdata", apb_prdata, 32'h0);
        check("rst_pslverr", 32'(apb_pslverr), 32'h0);
        rd_check("rst_status", 32'h08, 32'h2);
        rd_check("rst_level", 32'h0C, 32'h0);
        rd_check("rst_config", 32'h04, 32'h0);
        rd_check("unmapped_rd", 32'h14, 32'h0);
        rd_check("txdata_rd", 32'h00, 32'h0);
        rd_check("irq_en_rst", 32'h10, 32'h0);

        // 8N1 at div=3
        smp_q.delete();
        wr(32'h04, 32'h0003_B000);
        rd_check("config_rb", 32'h04, 32'h0003_B000);
        push_byte(8'h55, 8, 1'b0, 1, 3, 1'b0);
        check_frames();
        check_idle("idle_8n1");

        // 7 bits, even parity, 2 stop bits, div=0
        smp_q.delete();
        wr(32'h04, 32'h0000_E800);
        push_byte(8'h07, 7, 1'b1, 2, 0, 1'b0);
        check_frames();
        check_idle("idle_parity");

        // fill FIFO while disabled, overflow, then drain back to back
        wr(32'h04, 32'h0000_3000);
        smp_q.delete();
        for (int i = 0; i < 16; i++) push_byte(8'(i * 37 + 5), 8, 1'b0, 1, 0, i != 0);
        apb_write(32'h00, 32'hEE, err);
        check("overflow_pslverr", 32'(err), 32'h1);
        rd_check("full_status", 32'h08, 32'h4);
        rd_check("full_level", 32'h0C, 32'd16);
        wr(32'h04, 32'h0000_B000);
        check_frames();
        check_idle("idle_drain");
        rd_check("drain_level", 32'h0C, 32'h0);
        rd_check("drain_status", 32'h08, status_done);

        // divider change during the first frame only affects the second
        smp_q.delete();
        wr(32'h04, 32'h0003_B000);
        push_byte(8'hA5, 8, 1'b0, 1, 3, 1'b0);
        push_byte(8'h3C, 8, 1'b0, 1, 7, 1'b1);
        wr(32'h04, 32'h0007_B000);
        check_frames();
        check_idle("idle_cfgchg");

        // TX-empty interrupt
        wr(32'h10, 32'h1);
        rd_check("irq_en_rb", 32'h10, 32'(IRQ_FEAT));
        wr(32'h04, 32'h0000_B000);
        smp_q.delete();
        push_byte(8'h81, 8, 1'b0, 1, 0, 1'b0);
        push_byte(8'h18, 8, 1'b0, 1, 0, 1'b1);
        check_frames();
        tick();
        tick();
        check("irq_rise", 32'(uart_irq_o), 32'(IRQ_FEAT));
        rd_check("irq_status", 32'h08, status_done);
        wr(32'h08, 32'h8);
        tick();
        check("irq_w1c", 32'(uart_irq_o), 32'h0);
        rd_check("irq_status_clr", 32'h08, 32'h2);

        // reset in the middle of a frame
        wr(32'h04, 32'h0003_B000);
        wr(32'h00, 32'h00);
        wr(32'h00, 32'h00);
        repeat (3) tick();
        check("pre_rst_line", 32'(uart_tx_o), 32'h0);
        check("pre_rst_busy", 32'(busy_o), 32'h1);
        rst = 1'b1;
        tick();
        check("rst_mid_tx", 32'(uart_tx_o), 32'h1);
        check("rst_mid_busy", 32'(busy_o), 32'h0);
        rst = 1'b0;
        rd_check("rst_mid_level", 32'h0C, 32'h0);
        rd_check("rst_mid_config", 32'h04, 32'h0);
        repeat (4) tick();
        check("rst_mid_tx_hold", 32'(uart_tx_o), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
